// File: rtl/fifo_rd_ctrl_if.sv
// Valid/ready stream carrying words out of the FIFO read side.
// The master drives valid and data, and the slave drives ready.
interface fifo_rd_ctrl_if #(
  parameter int DSIZE = 8
);
  logic             m_valid;
  logic             m_ready;
  logic [DSIZE-1:0] m_data;

  modport master (
    output m_valid,
    output m_data,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_data,
    output m_ready
  );
endinterface

// File: rtl/fifo_rd_ctrl.sv
// Read-domain controller of the async FIFO: Gray read pointer, empty flag and
// a 2-entry skid buffer that hides the 1-cycle registered memory read latency.
module fifo_rd_ctrl #(
  parameter int DSIZE = 8,
  parameter int ASIZE = 4
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic [ASIZE:0]   rq2_wptr,
  output logic [ASIZE:0]   rptr,
  output logic [ASIZE-1:0] raddr,
  output logic             rclken,
  input  logic [DSIZE-1:0] mem_rdata,
  output logic             rempty,
  fifo_rd_ctrl_if.master   m
);

  logic [ASIZE:0]   rbin;
  logic [ASIZE:0]   rbinnext;
  logic [ASIZE:0]   rgraynext;
  logic             inflight;
  logic [1:0]       occ;
  logic [DSIZE-1:0] head;
  logic [DSIZE-1:0] tail;
  logic             pop;
  logic [2:0]       pending;

  assign m.m_valid = (occ != 2'd0);
  assign m.m_data  = head;
  assign raddr     = rbin[ASIZE-1:0];

  // Only issue a read if the word will have a buffer slot when it returns.
  always_comb begin
    pop       = m.m_valid && m.m_ready;
    pending   = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    rclken    = !rempty && (pending < 3'd2);
    rbinnext  = rbin + {{ASIZE{1'b0}}, rclken};
    rgraynext = (rbinnext >> 1) ^ rbinnext;
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin   <= '0;
      rptr   <= '0;
      rempty <= 1'b1;
    end else begin
      rbin   <= rbinnext;
      rptr   <= rgraynext;
      rempty <= (rgraynext == rq2_wptr);
    end
  end

  // The word read last cycle lands in the buffer now, and head always leaves first.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      inflight <= 1'b0;
      occ      <= 2'd0;
      head     <= '0;
      tail     <= '0;
    end else begin
      inflight <= rclken;
      case ({inflight, pop})
        2'b10: begin
          if (occ == 2'd0) begin
            head <= mem_rdata;
          end else begin
            tail <= mem_rdata;
          end
          occ <= occ + 2'd1;
        end
        2'b01: begin
          head <= tail;
          occ  <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            head <= mem_rdata;
          end else begin
            head <= tail;
            tail <= mem_rdata;
          end
        end
        default: begin
          occ <= occ;
        end
      endcase
    end
  end

endmodule
